// File: rtl/hdmi_vram_arbiter_if.sv
// Bus bundle for the HDMI VRAM arbiter: display fetch, CPU local bus and VRAM port.
// slave is the arbiter's view; master is the view of the requesters and the VRAM macro.
interface hdmi_vram_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 20,
  parameter int DW   = 8
);
  logic            disp_req;
  logic [AW-1:0]   disp_addr;
  logic            disp_gnt;
  logic            disp_rvalid;
  logic [DW-1:0]   disp_rdata;

  logic            cpu_sel;
  logic [XLEN-1:0] cpu_addr;
  logic [2:0]      cpu_we;
  logic [XLEN-1:0] cpu_qin;
  logic [XLEN-1:0] cpu_qout;
  logic            cpu_ready;

  logic            vram_en;
  logic            vram_we;
  logic [AW-1:0]   vram_addr;
  logic [DW-1:0]   vram_wdata;
  logic [DW-1:0]   vram_rdata;

  modport slave (
    input  disp_req, disp_addr, cpu_sel, cpu_addr, cpu_we, cpu_qin, vram_rdata,
    output disp_gnt, disp_rvalid, disp_rdata, cpu_qout, cpu_ready,
           vram_en, vram_we, vram_addr, vram_wdata
  );

  modport master (
    output disp_req, disp_addr, cpu_sel, cpu_addr, cpu_we, cpu_qin, vram_rdata,
    input  disp_gnt, disp_rvalid, disp_rdata, cpu_qout, cpu_ready,
           vram_en, vram_we, vram_addr, vram_wdata
  );
endinterface

// File: rtl/hdmi_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has priority, a starvation counter
// forces a CPU grant after STARVE_MAX consecutive display grants.
module hdmi_vram_arbiter #(
  parameter int              XLEN       = 32,
  parameter int              AW         = 20,
  parameter int              DW         = 8,
  parameter logic [XLEN-1:0] VRAM_BASE  = 32'h0020_0000,
  parameter int              STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  hdmi_vram_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RD, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU} owner_t;

  state_t          state;
  owner_t          rd_owner;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   rdata_hold;
  logic [XLEN-1:0] qout;
  logic            ready;

  logic [XLEN-1:0] cpu_off;
  logic            in_win, cpu_wr, cpu_pend, starved, cpu_gnt, disp_gnt;

  assign cpu_off  = bus.cpu_addr - VRAM_BASE;
  assign in_win   = (cpu_off[XLEN-1:AW] == '0);
  assign cpu_wr   = |bus.cpu_we;
  assign cpu_pend = !rst && bus.cpu_sel && in_win && (state == IDLE || state == WAIT);
  assign starved  = (cnt == CW'(STARVE_MAX));
  assign cpu_gnt  = cpu_pend && (!bus.disp_req || starved);
  // Grants are masked during reset so nothing reaches the VRAM macro.
  assign disp_gnt = !rst && bus.disp_req && !cpu_gnt;

  assign bus.disp_gnt    = disp_gnt;
  assign bus.vram_en     = cpu_gnt || disp_gnt;
  assign bus.vram_we     = cpu_gnt && cpu_wr;
  assign bus.vram_addr   = cpu_gnt ? cpu_off[AW-1:0] : bus.disp_addr;
  assign bus.vram_wdata  = bus.cpu_qin[DW-1:0];
  assign bus.disp_rvalid = (rd_owner == OWN_DISP);
  assign bus.disp_rdata  = bus.disp_rvalid ? bus.vram_rdata : rdata_hold;
  assign bus.cpu_qout    = qout;
  assign bus.cpu_ready   = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_owner   <= OWN_NONE;
      cnt        <= '0;
      rdata_hold <= '0;
      qout       <= '0;
      ready      <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (bus.disp_rvalid) rdata_hold <= bus.vram_rdata;
      rd_owner <= disp_gnt             ? OWN_DISP :
                  (cpu_gnt && !cpu_wr) ? OWN_CPU  : OWN_NONE;
      // Only count display grants that actually keep a CPU request waiting.
      if (disp_gnt && cpu_pend) cnt <= starved ? cnt : cnt + 1'b1;
      else                      cnt <= '0;

      case (state)
        IDLE, WAIT: begin
          if (cpu_gnt) begin
            state <= cpu_wr ? DONE : RD;
            ready <= cpu_wr;
            qout  <= '0;
          end else if (state == IDLE && bus.cpu_sel && !in_win) begin
            state <= DONE;
            ready <= 1'b1;
            qout  <= '0;
          end else begin
            state <= cpu_pend ? WAIT : IDLE;
          end
        end
        RD: begin
          qout  <= {{(XLEN-DW){1'b0}}, bus.vram_rdata};
          ready <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hdmi_vram_arbiter.sv
// Scoreboard bench for hdmi_vram_arbiter: drivers push expectations, a negedge
// monitor pops and compares against VRAM contents tracked in a shadow map.
module tb_hdmi_vram_arbiter;
  localparam int              XLEN = 32, AW = 20, DW = 8, SMAX = 8;
  localparam logic [31:0]     BASE = 32'h0020_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0, miscompares = 0;

  hdmi_vram_arbiter_if #(.XLEN(XLEN), .AW(AW), .DW(DW)) bus ();

  hdmi_vram_arbiter #(.XLEN(XLEN), .AW(AW), .DW(DW), .VRAM_BASE(BASE), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        chk_q;
    logic [31:0] qout;
    int          issue, lat_lo, lat_hi, gnts, dgnt;
    logic        we;
    logic [19:0] off;
    logic [7:0]  wd;
  } cexp_t;

  cexp_t      cq[$];
  logic [7:0] dq[$];
  logic [7:0] vmem[int];
  logic [7:0] shadow[int];

  // Unwritten VRAM words read back as the low byte of their address.
  function automatic logic [7:0] sh(input logic [19:0] a);
    logic [19:0] t;
    t = a;
    return shadow.exists(int'(a)) ? shadow[int'(a)] : t[7:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // VRAM macro model, one-cycle read latency
  always @(posedge clk) begin
    if (bus.vram_en) begin
      if (bus.vram_we) vmem[int'(bus.vram_addr)] = bus.vram_wdata;
      else bus.vram_rdata <= vmem.exists(int'(bus.vram_addr)) ? vmem[int'(bus.vram_addr)]
                                                             : bus.vram_addr[7:0];
    end
  end

  logic prev_dgnt = 1'b0;
  int   cpu_gnts = 0, dgnt_cnt = 0;

  always @(negedge clk) begin
    cexp_t e;
    logic  cg;
    int    lat;
    if (!rst) begin
      chk("disp_rvalid_timing", bus.disp_rvalid, prev_dgnt);
      cg = bus.vram_en && !bus.disp_gnt;
      if (bus.disp_gnt) begin
        chk("disp_vram_addr", bus.vram_addr, bus.disp_addr);
        chk("disp_no_write", bus.vram_we, 1'b0);
      end
      if (cg) begin
        if (cq.size() == 0) chk("cpu_gnt_unexpected", 1, 0);
        else begin
          e = cq[0];
          chk("cpu_vram_addr", bus.vram_addr, e.off);
          chk("cpu_vram_we", bus.vram_we, e.we);
          if (e.we) chk("cpu_vram_wdata", bus.vram_wdata, e.wd);
          if (e.dgnt >= 0) chk("starve_disp_grants", dgnt_cnt, e.dgnt);
        end
        cpu_gnts++;
      end else if (bus.disp_gnt && cq.size() != 0 && cpu_gnts == 0) begin
        dgnt_cnt++;
      end
      if (bus.disp_rvalid) begin
        if (dq.size() == 0) chk("disp_rvalid_unexpected", 1, 0);
        else chk("disp_rdata", bus.disp_rdata, dq.pop_front());
      end
      if (bus.cpu_ready) begin
        if (cq.size() == 0) chk("cpu_ready_unexpected", 1, 0);
        else begin
          e   = cq.pop_front();
          lat = cyc - e.issue;
          chk("cpu_vram_accesses", cpu_gnts, e.gnts);
          if (e.chk_q) chk("cpu_qout", bus.cpu_qout, e.qout);
          if (e.lat_lo == e.lat_hi) chk("cpu_latency", lat, e.lat_lo);
          else chk("cpu_latency_bound", (lat >= e.lat_lo && lat <= e.lat_hi), 1);
        end
        cpu_gnts = 0;
        dgnt_cnt = 0;
      end
    end else begin
      cpu_gnts = 0;
      dgnt_cnt = 0;
    end
    prev_dgnt = bus.disp_gnt && !rst;
  end

  // Called at posedge+1; returns at posedge+1 after the grant edge.
  task automatic disp_word(input logic [19:0] a, output int gcyc);
    int n = 0;
    bus.disp_req  = 1'b1;
    bus.disp_addr = a;
    dq.push_back(sh(a));
    @(negedge clk);
    while (!bus.disp_gnt && n < 40) begin n++; @(negedge clk); end
    if (!bus.disp_gnt) chk("disp_gnt_timeout", 0, 1);
    gcyc = cyc;
    @(posedge clk); #1;
    bus.disp_req = 1'b0;
  endtask

  task automatic cpu_xact(input logic [31:0] a, input logic [2:0] we, input logic [31:0] d,
                          input int lo, input int hi, input int dg);
    cexp_t       e;
    logic [31:0] off;
    logic        inw;
    int          n = 0;
    off = a - BASE;
    inw = (off < 32'h0010_0000);
    e.issue = cyc; e.lat_lo = lo; e.lat_hi = hi; e.dgnt = dg;
    e.gnts  = inw ? 1 : 0;
    e.we    = (we != 3'd0);
    e.off   = off[19:0];
    e.wd    = d[7:0];
    e.chk_q = !(inw && we != 3'd0);
    e.qout  = (inw && we == 3'd0) ? {24'h0, sh(off[19:0])} : 32'h0;
    if (inw && we != 3'd0) shadow[int'(off[19:0])] = d[7:0];
    cq.push_back(e);
    bus.cpu_sel = 1'b1; bus.cpu_addr = a; bus.cpu_we = we; bus.cpu_qin = d;
    @(negedge clk);
    while (!bus.cpu_ready && n < 40) begin n++; @(negedge clk); end
    if (!bus.cpu_ready) chk("cpu_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.cpu_sel = 1'b0;
  endtask

  initial begin
    int    g0, g1, gx;
    cexp_t e;
    int    n;
    bus.disp_req = 1'b1; bus.disp_addr = '0;
    bus.cpu_sel = 1'b1; bus.cpu_addr = 32'h0020_0010; bus.cpu_we = 3'd0; bus.cpu_qin = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vram_en", bus.vram_en, 1'b0);
    chk("rst_cpu_ready", bus.cpu_ready, 1'b0);
    chk("rst_disp_rvalid", bus.disp_rvalid, 1'b0);
    chk("rst_cpu_qout", bus.cpu_qout, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; bus.cpu_sel = 1'b0; bus.disp_req = 1'b0;
    @(posedge clk); #1;

    // display stream 0..15, back to back
    disp_word(20'd0, g0);
    for (int i = 1; i < 16; i++) disp_word(20'(i), g1);
    chk("disp_stream_no_gaps", g1 - g0, 15);
    repeat (2) begin @(posedge clk); #1; end

    cpu_xact(32'h0020_0005, 3'd1, 32'h0000_00A5, 1, 1, -1);
    cpu_xact(32'h0020_0005, 3'd0, 32'h0, 2, 2, -1);
    cpu_xact(32'h0010_0000, 3'd0, 32'h0, 1, 1, -1);

    // starvation: continuous display stream while a CPU write waits
    fork
      for (int i = 0; i < 20; i++) disp_word(20'(16 + i), gx);
      begin
        repeat (3) begin @(posedge clk); #1; end
        cpu_xact(32'h0020_1000, 3'd2, 32'h0000_005C, SMAX + 1, SMAX + 1, SMAX);
      end
    join
    repeat (2) begin @(posedge clk); #1; end

    // reset while the CPU read sits in RD, then re-issue from scratch
    e.issue = cyc; e.lat_lo = 4; e.lat_hi = 4; e.dgnt = -1; e.gnts = 1;
    e.we = 1'b0; e.off = 20'h5; e.wd = 8'h0; e.chk_q = 1'b1; e.qout = {24'h0, sh(20'h5)};
    cq.push_back(e);
    bus.cpu_sel = 1'b1; bus.cpu_addr = 32'h0020_0005; bus.cpu_we = 3'd0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cpu_ready", bus.cpu_ready, 1'b0);
    n = 0;
    while (!bus.cpu_ready && n < 40) begin n++; @(negedge clk); end
    if (!bus.cpu_ready) chk("mid_rst_ready_timeout", 0, 1);
    @(posedge clk); #1; bus.cpu_sel = 1'b0;
    @(posedge clk); #1;

    // randomized traffic; display region 16..255 is disjoint from CPU writes
    fork
      for (int i = 0; i < 60; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        disp_word(20'($urandom_range(16, 255)), gx);
      end
      for (int i = 0; i < 30; i++) begin
        logic [31:0] a;
        logic [2:0]  w;
        w = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        case ($urandom_range(0, 4))
          0:       a = 32'h0010_0000 + $urandom_range(0, 255);
          1:       a = 32'h0030_0000 + $urandom_range(0, 255);
          default: a = 32'h0020_1000 + $urandom_range(0, 7);
        endcase
        if (a >= 32'h0020_0000 && a < 32'h0030_0000)
          cpu_xact(a, w, $urandom, (w != 0) ? 1 : 2, (w != 0) ? SMAX + 1 : SMAX + 2, -1);
        else
          cpu_xact(a, w, $urandom, 1, 1, -1);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    join

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("cpu_queue_drained", cq.size(), 0);
    chk("disp_queue_drained", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
